// File: rtl/cdc_xfer_arbiter.sv
// Source-domain sequencer: arbitrates requesters onto one recirculation-mux synchronizer.
// Define CDC_XFER_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module cdc_xfer_arbiter #(
   parameter int BITS_WIDTH   = 5,
   parameter int NUM_REQ      = 4,
   parameter int PULSE_CYCLES = 2,
   parameter int HOLD_CYCLES  = 3
) (
   input  logic                          clk_src,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*BITS_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic                          done,
   output logic [BITS_WIDTH-1:0]         sync_data,
   output logic                          sync_ctrl
);

   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int MAX_PH = (PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES;
   localparam int CNT_W  = $clog2(MAX_PH + 1);

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

   state_t                  state, state_d;
   logic [CNT_W-1:0]        cnt, cnt_d;
   logic [PTR_W-1:0]        winner;
   logic [BITS_WIDTH-1:0]   sel_data;
   logic                    any_req;
   logic                    take;
   logic [NUM_REQ-1:0]      grant_d;
   logic [BITS_WIDTH-1:0]   sync_data_d;
   logic                    busy_d, done_d, sync_ctrl_d;

   assign any_req = |req;
   assign take    = (state == IDLE) && any_req;

`ifdef CDC_XFER_RR_EN
   logic [PTR_W-1:0] rr_ptr;

   // Search upward from the pointer, wrapping past NUM_REQ-1 back to 0.
   always_comb begin
      logic             found;
      logic [PTR_W:0]   cand;
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(NUM_REQ))
            cand = cand - (PTR_W+1)'(NUM_REQ);
         if (!found && req[cand[PTR_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[PTR_W-1:0];
         end
      end
   end

   always_ff @(posedge clk_src) begin
      if (rst)
         rr_ptr <= '0;
      else if (take)
         rr_ptr <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
   end
`else
   always_comb begin
      winner = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req[k]) winner = PTR_W'(k);
   end
`endif

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (winner == PTR_W'(k)) sel_data = req_data[k*BITS_WIDTH +: BITS_WIDTH];
   end

   // State register; every output is registered here alongside the FSM.
   always_ff @(posedge clk_src) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         grant     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sync_data <= '0;
         sync_ctrl <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         grant     <= grant_d;
         busy      <= busy_d;
         done      <= done_d;
         sync_data <= sync_data_d;
         sync_ctrl <= sync_ctrl_d;
      end
   end

   // Next state; the phase counter is reloaded on every state entry.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a latch behind.
      state_d = state;
      cnt_d   = cnt;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_d = SETUP;
               cnt_d   = '0;
            end
         end
         SETUP: begin
            state_d = PULSE;
            cnt_d   = CNT_W'(PULSE_CYCLES - 1);
         end
         PULSE: begin
            if (cnt == '0) begin
               state_d = HOLD;
               cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         HOLD: begin
            if (cnt == '0) state_d = IDLE;
            else           cnt_d   = cnt - 1'b1;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output values for the cycle after this edge, derived from the next state.
   always_comb begin
      grant_d     = take ? (NUM_REQ'(1) << winner) : '0;
      sync_data_d = take ? sel_data : sync_data;
      busy_d      = (state_d != IDLE);
      sync_ctrl_d = (state_d == PULSE);
      done_d      = (state_d == HOLD) && (cnt_d == '0);
   end

endmodule
